console_uart_tx: RTL and testbench

- Synthesizable memory-mapped console peripheral on the core's data memory interface.
- Replaces the simulation-only printf sink at 0x1000_0000.
- Byte writes to TXDATA are queued in a FIFO and serialized 8N1, LSB first, on a UART TX line.
- A read-only STATUS register lets firmware poll FIFO and transmitter state.

---
 rtl/console_uart_tx_pkg.sv | 37 +++
 rtl/console_fifo.sv | 74 +++++++
 rtl/console_uart_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_console_uart_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_uart_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : console_uart_tx_pkg                                    |
// | Description : Shared defines for the console UART peripheral:        |
// |               register offsets, STATUS bit positions, TX FSM states  |
// |               and the core's READ/WRITE bus encoding.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package console_uart_tx_pkg;

  // Register offsets from BASE_ADDRESS; only bit 2 distinguishes them.
  localparam logic [2:0] OFFSET_TXDATA = 3'h0;
  localparam logic [2:0] OFFSET_STATUS = 3'h4;

  // STATUS register layout.
  localparam int STATUS_FULL_BIT   = 0;
  localparam int STATUS_EMPTY_BIT  = 1;
  localparam int STATUS_BUSY_BIT   = 2;
  localparam int STATUS_OVF_BIT    = 3;
  localparam int STATUS_PARITY_BIT = 4;
  localparam int STATUS_COUNT_LSB  = 8;

  // Bus direction encoding shared with the core.
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Transmitter states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/console_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : console_fifo                                           |
// | Description : Synchronous FIFO for console TX bytes. Pushes to a     |
// |               full FIFO and pops from an empty FIFO are ignored.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module console_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/console_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : console_uart_tx                                        |
// | Description : Memory-mapped console. Byte writes to TXDATA are       |
// |               queued and sent 8N1, LSB first, on uart_tx. STATUS is  |
// |               readable for FIFO/transmitter state.                   |
// |               Define CONSOLE_PARITY_EN for an even-parity bit.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module console_uart_tx
  import console_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_memory_interface_enable,
  input  logic        data_memory_interface_state,
  input  logic [31:0] data_memory_interface_address,
  input  logic [3:0]  data_memory_interface_frame_mask,
  inout  wire  [31:0] data_memory_interface_data,
  output logic        uart_tx,
  output logic        console_idle
);

  localparam int                FIFO_AW   = $clog2(FIFO_DEPTH);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
`ifdef CONSOLE_PARITY_EN
  localparam logic              PARITY_EN = 1'b1;
`else
  localparam logic              PARITY_EN = 1'b0;
`endif

  // ---------------- Address decode ----------------
  logic addr_hit, push_req, status_rd, txdata_rd, overflow_q, overflow_d;
  logic unused_bits;

  assign addr_hit  = (data_memory_interface_address[31:3] == BASE_ADDRESS[31:3]);
  assign push_req  = data_memory_interface_enable && (data_memory_interface_state == MEM_WRITE)
                  && addr_hit && (data_memory_interface_address[2] == OFFSET_TXDATA[2])
                  && data_memory_interface_frame_mask[3];
  assign status_rd = data_memory_interface_enable && (data_memory_interface_state == MEM_READ)
                  && addr_hit && (data_memory_interface_address[2] == OFFSET_STATUS[2]);
  assign txdata_rd = data_memory_interface_enable && (data_memory_interface_state == MEM_READ)
                  && addr_hit && (data_memory_interface_address[2] == OFFSET_TXDATA[2]);
  // Byte offset and the other lanes carry nothing for this block.
  assign unused_bits = ^{data_memory_interface_address[1:0],
                         data_memory_interface_frame_mask[2:0],
                         data_memory_interface_data[31:8]};

  // ---------------- TX FIFO ----------------
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [FIFO_AW:0] fifo_count;

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .data_i  (data_memory_interface_data[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Sticky overflow: a STATUS read clears it, a dropped byte on the same edge wins.
  always_comb begin
    overflow_d = overflow_q;
    if (status_rd)             overflow_d = 1'b0;
    if (push_req && fifo_full) overflow_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  // ---------------- TX FSM ----------------
  tx_state_e         state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              tx_q, tx_d, tx_busy, baud_done;

  assign baud_done = (baud_q == '0);
  assign uart_tx   = tx_q;

  // FSM and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Next state: the shift register rotates so its LSB is always the next data bit.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          tx_d     = 1'b0;
          baud_d   = BAUD_LAST;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          tx_d    = shift_q[0];
          shift_d = {shift_q[0], shift_q[7:1]};
          bit_d   = 3'd0;
          baud_d  = BAUD_LAST;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_LAST;
          if (bit_q == 3'd7) begin
`ifdef CONSOLE_PARITY_EN
            tx_d    = ^shift_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = {shift_q[0], shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
`ifdef CONSOLE_PARITY_EN
      ST_PARITY: begin
        if (baud_done) begin
          tx_d    = 1'b1;
          baud_d  = BAUD_LAST;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            tx_d     = 1'b0;
            baud_d   = BAUD_LAST;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs derived from FSM and FIFO state.
  always_comb begin
    tx_busy      = (state_q != ST_IDLE);
    console_idle = fifo_empty && !tx_busy;
  end

  // ---------------- Read path ----------------
  logic [7:0]  count_ext;
  logic [31:0] status_word, rd_data;

  // STATUS register image.
  always_comb begin
    count_ext                                 = '0;
    count_ext[FIFO_AW:0]                      = fifo_count;
    status_word                               = '0;
    status_word[STATUS_FULL_BIT]              = fifo_full;
    status_word[STATUS_EMPTY_BIT]             = fifo_empty;
    status_word[STATUS_BUSY_BIT]              = tx_busy;
    status_word[STATUS_OVF_BIT]               = overflow_q;
    status_word[STATUS_PARITY_BIT]            = PARITY_EN;
    status_word[STATUS_COUNT_LSB +: 8]        = count_ext;
    rd_data                                   = status_rd ? status_word : 32'h0;
  end

  // Drive the shared bus only while answering a read that hits this block.
  assign data_memory_interface_data = (status_rd || txdata_rd) ? rd_data : 32'bz;

endmodule
`default_nettype wire

// File: tb/tb_console_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_console_uart_tx                                     |
// | Description : Scoreboard bench for console_uart_tx. Expected frames  |
// |               and bus read values are queued at stimulus time and    |
// |               checked by independent UART and bus monitors.          |
// |               Honours CONSOLE_PARITY_EN.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_console_uart_tx;
  import console_uart_tx_pkg::*;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;
`ifdef CONSOLE_PARITY_EN
  localparam int          NBITS = 11;
  localparam logic [31:0] PB    = 32'h0000_0010;
`else
  localparam int          NBITS = 10;
  localparam logic [31:0] PB    = 32'h0000_0000;
`endif
  localparam int          FRAME = NBITS * CPB;

  logic        clk = 1'b0, reset = 1'b1, en = 1'b0, st = MEM_READ;
  logic [31:0] addr = '0, tb_data = '0;
  logic [3:0]  mask = '0;
  logic        tb_drive = 1'b0, rd_active = 1'b0, mon_en = 1'b0;
  logic        uart_tx, console_idle;
  wire  [31:0] bus;
  string       rd_tag = "";

  int          checks = 0, errors = 0, cyc = 0, epoch = 0, last_wr = 0;
  int          start_q[$];
  logic [10:0] exp_frames[$];
  logic [31:0] exp_bus[$];

  assign bus = tb_drive ? tb_data : 32'bz;

  console_uart_tx #(
    .BASE_ADDRESS (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk                              (clk),
    .reset                            (reset),
    .data_memory_interface_enable     (en),
    .data_memory_interface_state      (st),
    .data_memory_interface_address    (addr),
    .data_memory_interface_frame_mask (mask),
    .data_memory_interface_data       (bus),
    .uart_tx                          (uart_tx),
    .console_idle                     (console_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, expv);
    end
  endtask

  // Line image of one frame: start, 8 data LSB first, [parity], stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef CONSOLE_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; st = MEM_WRITE; addr = a; mask = m; tb_data = d; tb_drive = 1'b1;
    @(posedge clk); #1;
    last_wr = cyc;
    en = 1'b0; tb_drive = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic drv,
                          input logic [31:0] pat, input logic [31:0] expv);
    @(negedge clk);
    en = 1'b1; st = MEM_READ; addr = a; mask = 4'b1111; tb_drive = drv; tb_data = pat;
    rd_tag = tag; exp_bus.push_back(expv); rd_active = 1'b1;
    @(posedge clk); #1;
    rd_active = 1'b0; en = 1'b0; tb_drive = 1'b0;
  endtask

  task automatic wait_cycles_to(input int target);
    int b = 0;
    while (cyc < target && b < 5000) begin @(posedge clk); #1; b++; end
  endtask

  task automatic wait_starts(input int n, input string name);
    int b = 0;
    while (start_q.size() < n && b < 3 * FRAME) begin @(posedge clk); #1; b++; end
    check(name, 32'(start_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int bound, input string name);
    int b = 0;
    while (console_idle !== 1'b1 && b < bound) begin @(posedge clk); #1; b++; end
    check(name, 32'(console_idle), 32'd1);
  endtask

  task automatic send_timed(input logic [7:0] b);
    start_q.delete();
    exp_frames.push_back(make_frame(b));
    bus_write(BASE, 4'b1000, {24'hABCDEF, b});
    wait_starts(1, "start_seen");
    if (start_q.size() >= 1) begin
      check("start_latency", start_q[0], last_wr + 1);
      wait_cycles_to(start_q[0] + FRAME - 1);
      check("busy_before_frame_end", 32'(console_idle), 32'd0);
      wait_cycles_to(start_q[0] + FRAME);
      check("idle_at_frame_end", 32'(console_idle), 32'd1);
    end
  endtask

  // Bus monitor: compare every read this bench issues against the queued value.
  always @(negedge clk) begin
    #2;
    if (rd_active) begin
      if (exp_bus.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s: read with no queued expectation, bus 0x%08h", rd_tag, bus);
      end else begin
        check(rd_tag, bus, exp_bus.pop_front());
      end
    end
  end

  // UART monitor: sample each bit near its middle and score whole frames.
  initial begin : uart_mon
    logic [10:0] got;
    int          ep;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && uart_tx == 1'b0) begin
        ep = epoch;
        start_q.push_back(cyc);
        got = '1;
        @(negedge clk);
        got[0] = uart_tx;
        for (int k = 1; k < NBITS; k++) begin
          repeat (CPB) @(negedge clk);
          got[k] = uart_tx;
        end
        if (ep == epoch) begin
          if (exp_frames.size() == 0) begin
            checks++; errors++;
            $display("FAIL uart_unexpected_frame: actual 0x%03h required no frame", got);
          end else begin
            check("uart_frame", 32'(got), 32'(exp_frames.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          first_wr;
    logic [7:0]  bv;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_uart_tx", 32'(uart_tx), 32'd1);
    check("reset_console_idle", 32'(console_idle), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    bus_read("status_after_por", BASE + 32'h4, 1'b0, '0, 32'h0000_0002 | PB);

    // Single byte with exact timing
    send_timed(8'h41);

    // Back-to-back bytes: no idle gap between frames
    start_q.delete();
    exp_frames.push_back(make_frame(8'h48));
    exp_frames.push_back(make_frame(8'h49));
    bus_write(BASE, 4'b1000, 32'h0000_0048);
    first_wr = last_wr;
    bus_write(BASE, 4'b1000, 32'h0000_0049);
    bus_read("status_count_during_frame", BASE + 32'h4, 1'b0, '0, 32'h0000_0104 | PB);
    wait_starts(2, "b2b_starts_seen");
    if (start_q.size() >= 2) begin
      check("b2b_first_start", start_q[0], first_wr + 1);
      check("b2b_no_gap", start_q[1] - start_q[0], FRAME);
    end
    wait_idle(3 * FRAME, "b2b_idle");

    // Overflow: one byte in flight, then 17 more into a 16-deep FIFO
    start_q.delete();
    exp_frames.push_back(make_frame(8'hA5));
    bus_write(BASE, 4'b1000, 32'h0000_00A5);
    for (int k = 1; k <= 17; k++) begin
      bv = 8'(16 + k);
      if (k <= 16) exp_frames.push_back(make_frame(bv));
      bus_write(BASE, 4'b1000, {24'h0, bv});
    end
    bus_read("status_overflow", BASE + 32'h4, 1'b0, '0, 32'h0000_100D | PB);
    bus_read("status_overflow_cleared", BASE + 32'h4, 1'b0, '0, 32'h0000_1005 | PB);
    wait_idle(18 * FRAME + 100, "overflow_idle");
    check("overflow_frames_drained", exp_frames.size(), 32'd0);

    // Ignored accesses: wrong lane, non-hit address, STATUS write
    start_q.delete();
    bus_write(BASE, 4'b0001, 32'h0000_00FF);
    bus_write(BASE + 32'h8, 4'b1000, 32'h0000_005A);
    bus_write(BASE + 32'h4, 4'b1000, 32'h0000_0077);
    bus_read("status_after_ignored", BASE + 32'h4, 1'b0, '0, 32'h0000_0002 | PB);
    bus_read("status_byte_offset", BASE + 32'h6, 1'b0, '0, 32'h0000_0002 | PB);
    bus_read("txdata_read_zero", BASE, 1'b0, '0, 32'h0000_0000);
    bus_read("nonhit_read_released", BASE + 32'h8, 1'b1, 32'h0000_00F0, 32'h0000_00F0);
    bus_read("nonhit_low_read_released", 32'h0000_0004, 1'b1, 32'h0000_00F0, 32'h0000_00F0);
    repeat (20) @(posedge clk);
    #1;
    check("ignored_no_frame", start_q.size(), 32'd0);
    check("ignored_line_high", 32'(uart_tx), 32'd1);

    // Reset in the middle of a data bit with bytes queued
    start_q.delete();
    exp_frames.push_back(make_frame(8'h31));
    exp_frames.push_back(make_frame(8'h32));
    exp_frames.push_back(make_frame(8'h33));
    bus_write(BASE, 4'b1000, 32'h0000_0031);
    bus_write(BASE, 4'b1000, 32'h0000_0032);
    bus_write(BASE, 4'b1000, 32'h0000_0033);
    wait_starts(1, "reset_test_start_seen");
    if (start_q.size() >= 1) begin
      wait_cycles_to(start_q[0] + 9);
      check("pre_reset_data_bit_low", 32'(uart_tx), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    epoch++;
    exp_frames.delete();
    @(posedge clk); #1;
    check("midframe_reset_line_high", 32'(uart_tx), 32'd1);
    check("midframe_reset_idle", 32'(console_idle), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus_read("status_after_midframe_reset", BASE + 32'h4, 1'b0, '0, 32'h0000_0002 | PB);
    repeat (3 * FRAME) @(posedge clk);
    #1;
    check("no_frame_after_reset", start_q.size(), 32'd1);
    check("line_high_after_reset", 32'(uart_tx), 32'd1);

    // Byte with odd bit count (parity bit 1 when enabled)
    send_timed(8'h07);

    check("frames_all_seen", exp_frames.size(), 32'd0);
    check("bus_reads_all_seen", exp_bus.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
